// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register slice:
//   - XLEN           default datapath width
//   - CtrlW          width of the packed decode control word
//   - Ctrl*          bit positions inside the control word
//   - alu_op_e       ALU operation encodings carried in ctrl[3:0]
//   - ctrl_* helpers field extractors for the control word
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RegW   = 5;
    localparam int unsigned CtrlW  = 10;

    // Control word layout: {reg_write, mem_read, mem_write, mem_to_reg,
    //                       alu_src, branch, alu_op[3:0]}
    localparam int unsigned CtrlRegWrite = 9;
    localparam int unsigned CtrlMemRead  = 8;
    localparam int unsigned CtrlMemWrite = 7;
    localparam int unsigned CtrlMemToReg = 6;
    localparam int unsigned CtrlAluSrc   = 5;
    localparam int unsigned CtrlBranch   = 4;
    localparam int unsigned CtrlAluOpMsb = 3;
    localparam int unsigned CtrlAluOpLsb = 0;

    typedef enum logic [3:0] {
        AluAdd  = 4'h0,
        AluSub  = 4'h1,
        AluAnd  = 4'h2,
        AluOr   = 4'h3,
        AluXor  = 4'h4,
        AluSll  = 4'h5,
        AluSrl  = 4'h6,
        AluSra  = 4'h7,
        AluSlt  = 4'h8,
        AluSltu = 4'h9,
        AluLui  = 4'hA,
        AluPass = 4'hB
    } alu_op_e;

    function automatic logic ctrl_mem_read(input logic [CtrlW-1:0] ctrl);
        return ctrl[CtrlMemRead];
    endfunction

    function automatic logic ctrl_reg_write(input logic [CtrlW-1:0] ctrl);
        return ctrl[CtrlRegWrite];
    endfunction

    function automatic alu_op_e ctrl_alu_op(input logic [CtrlW-1:0] ctrl);
        return alu_op_e'(ctrl[CtrlAluOpMsb:CtrlAluOpLsb]);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// id_ex_stage_hazard_detect
// Combinational load-use hazard detection and decode-stall generation.
// Ports:
//   id_valid_i, id_rs1_i, id_rs2_i,
//   id_uses_rs1_i, id_uses_rs2_i   decode-stage instruction and its sources
//   ex_valid_i, ex_mem_read_i,
//   ex_rd_i                         instruction currently in EX
//   hold_i, flush_i                 downstream stall / redirect
//   lu_o                            load-use hazard (raw, ungated by flush/hold)
//   stall_id_o                      freeze PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic            id_valid_i,
    input  logic [RegW-1:0] id_rs1_i,
    input  logic [RegW-1:0] id_rs2_i,
    input  logic            id_uses_rs1_i,
    input  logic            id_uses_rs2_i,
    input  logic            ex_valid_i,
    input  logic            ex_mem_read_i,
    input  logic [RegW-1:0] ex_rd_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            lu_o,
    output logic            stall_id_o
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
        // ex_valid gating keeps a stale ex_rd from a bubble from raising a hazard
        lu_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != '0)
               && (rs1_match || rs2_match);
        // A redirect kills the decode instruction, so there is nothing to stall
        stall_id_o = (lu_o || hold_i) && !flush_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with writeback bypass into the captured operands,
// load-use bubble insertion and a saturating bubble counter.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   id_valid, id_pc, id_imm, id_rs1,
//   id_rs2, id_rd, id_uses_rs1/2,
//   id_ctrl                           decoded instruction
//   rf_rdata1, rf_rdata2              combinational register-file read data
//   wb_reg_write, wb_rd, wb_data      writeback port (bypass source)
//   flush                             redirect from EX, kills decode instr
//   hold                              downstream stall, freezes this stage
//   stall_id                          freeze PC and IF/ID this cycle
//   ex_*                              registered EX-stage fields
//   bubble_count                      saturating count of load-use bubbles
// Edge priority: flush > hold > load-use bubble > capture.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned XLEN = id_ex_stage_pkg::XLEN
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                id_valid,
    input  logic [XLEN-1:0]                     id_pc,
    input  logic [XLEN-1:0]                     id_imm,
    input  logic [4:0]                          id_rs1,
    input  logic [4:0]                          id_rs2,
    input  logic [4:0]                          id_rd,
    input  logic                                id_uses_rs1,
    input  logic                                id_uses_rs2,
    input  logic [XLEN-1:0]                     rf_rdata1,
    input  logic [XLEN-1:0]                     rf_rdata2,
    input  logic [id_ex_stage_pkg::CtrlW-1:0]   id_ctrl,
    input  logic                                wb_reg_write,
    input  logic [4:0]                          wb_rd,
    input  logic [XLEN-1:0]                     wb_data,
    input  logic                                flush,
    input  logic                                hold,
    output logic                                stall_id,
    output logic                                ex_valid,
    output logic [XLEN-1:0]                     ex_pc,
    output logic [XLEN-1:0]                     ex_imm,
    output logic [XLEN-1:0]                     ex_op1,
    output logic [XLEN-1:0]                     ex_op2,
    output logic [4:0]                          ex_rs1,
    output logic [4:0]                          ex_rs2,
    output logic [4:0]                          ex_rd,
    output logic [id_ex_stage_pkg::CtrlW-1:0]   ex_ctrl,
    output logic [31:0]                         bubble_count
);

    import id_ex_stage_pkg::*;

    logic             lu;

    logic [XLEN-1:0]  op1_byp;
    logic [XLEN-1:0]  op2_byp;

    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
    logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
    logic [XLEN-1:0]  ex_op2_q, ex_op2_d;
    logic [RegW-1:0]  ex_rs1_q, ex_rs1_d;
    logic [RegW-1:0]  ex_rs2_q, ex_rs2_d;
    logic [RegW-1:0]  ex_rd_q, ex_rd_d;
    logic [CtrlW-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0]      bubble_count_q, bubble_count_d;

    id_ex_stage_hazard_detect hazard_detect (
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ctrl_mem_read(ex_ctrl_q)),
        .ex_rd_i       (ex_rd_q),
        .hold_i        (hold),
        .flush_i       (flush),
        .lu_o          (lu),
        .stall_id_o    (stall_id)
    );

    // Writeback bypass: the register file is read in the same cycle it is
    // written, so forward the writeback value. x0 never forwards.
    always_comb begin
        op1_byp = rf_rdata1;
        op2_byp = rf_rdata2;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) begin
            op1_byp = wb_data;
        end
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) begin
            op2_byp = wb_data;
        end
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_pc_d        = ex_pc_q;
        ex_imm_d       = ex_imm_q;
        ex_op1_d       = ex_op1_q;
        ex_op2_d       = ex_op2_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_ctrl_d      = ex_ctrl_q;
        bubble_count_d = bubble_count_q;

        if (flush) begin
            ex_valid_d = 1'b0;
            ex_pc_d    = '0;
            ex_imm_d   = '0;
            ex_op1_d   = '0;
            ex_op2_d   = '0;
            ex_rs1_d   = '0;
            ex_rs2_d   = '0;
            ex_rd_d    = '0;
            ex_ctrl_d  = '0;
        end else if (hold) begin
            // Everything retains its value.
        end else if (lu) begin
            // Bubble: only valid and ctrl matter; the data fields are ignored
            // downstream while ex_valid is low.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (bubble_count_q != 32'hFFFF_FFFF) begin
                bubble_count_d = bubble_count_q + 32'd1;
            end
        end else begin
            ex_valid_d = id_valid;
            ex_pc_d    = id_pc;
            ex_imm_d   = id_imm;
            ex_op1_d   = op1_byp;
            ex_op2_d   = op2_byp;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_imm_q       <= '0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_ctrl_q      <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_imm_q       <= ex_imm_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_ctrl_q      <= ex_ctrl_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_imm       = ex_imm_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed testbench for id_ex_stage: reset, capture, bypass, load-use,
// flush priority, hold, invalid-EX, asynchronous reset and saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;
    localparam logic [9:0] CtrlLw  = 10'h360;  // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [9:0] CtrlAdd = 10'h200;  // reg_write, alu_op=add

    logic            clk;
    logic            reset;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic [9:0]      id_ctrl;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush, hold;
    logic            stall_id;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [9:0]      ex_ctrl;
    logic [31:0]     bubble_count;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_imm       (id_imm),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .id_ctrl      (id_ctrl),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .hold         (hold),
        .stall_id     (stall_id),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid     = 1'b0;
        id_pc        = '0;
        id_imm       = '0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        rf_rdata1    = '0;
        rf_rdata2    = '0;
        id_ctrl      = '0;
        wb_reg_write = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        flush        = 1'b0;
        hold         = 1'b0;
    endtask

    // Put a valid "lw x<rd>" in ID (source x1, not a hazard against anything).
    task automatic drive_lw(input logic [4:0] rd, input logic [31:0] pc);
        clear_id();
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs1      = 5'd1;
        id_uses_rs1 = 1'b1;
        id_rd       = rd;
        id_ctrl     = CtrlLw;
    endtask

    // Put a valid "add x5, x3, x4" in ID.
    task automatic drive_add_x3(input logic [31:0] pc);
        clear_id();
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs1      = 5'd3;
        id_rs2      = 5'd4;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
        id_rd       = 5'd5;
        id_ctrl     = CtrlAdd;
    endtask

    task automatic test_reset();
        clear_id();
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ex_valid: got %0h exp 0", ex_valid);
        end
        n_checks++;
        if (ex_ctrl !== 10'h0) begin
            n_fail++; $display("FAIL reset_ex_ctrl: got %0h exp 0", ex_ctrl);
        end
        n_checks++;
        if (bubble_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_bubble_count: got %0h exp 0", bubble_count);
        end
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_id: got %0h exp 0", stall_id);
        end
        // Valid ID input while reset is held must not be captured.
        drive_lw(5'd3, 32'h10);
        tick();
        tick();
        n_checks++;
        if ({ex_valid, ex_pc, ex_op1} !== '0) begin
            n_fail++; $display("FAIL reset_held: got valid=%0h pc=%0h op1=%0h exp 0",
                               ex_valid, ex_pc, ex_op1);
        end
        reset = 1'b0;
    endtask

    task automatic test_capture();
        clear_id();
        id_valid    = 1'b1;
        id_pc       = 32'h0000_0100;
        id_imm      = 32'hFFFF_FFFC;
        id_rs1      = 5'd5;
        id_rs2      = 5'd6;
        id_rd       = 5'd10;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
        rf_rdata1   = 32'h0000_1234;
        rf_rdata2   = 32'h0000_0055;
        id_ctrl     = CtrlAdd;
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL capture_stall: got %0h exp 0", stall_id);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL capture_valid: got %0h exp 1", ex_valid);
        end
        n_checks++;
        if (ex_op1 !== 32'h0000_1234) begin
            n_fail++; $display("FAIL capture_op1: got %0h exp 1234", ex_op1);
        end
        n_checks++;
        if (ex_op2 !== 32'h0000_0055) begin
            n_fail++; $display("FAIL capture_op2: got %0h exp 55", ex_op2);
        end
        n_checks++;
        if ({ex_pc, ex_imm} !== {32'h0000_0100, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL capture_pc_imm: got %0h %0h exp 100 fffffffc", ex_pc, ex_imm);
        end
        n_checks++;
        if ({ex_rs1, ex_rs2, ex_rd, ex_ctrl} !== {5'd5, 5'd6, 5'd10, CtrlAdd}) begin
            n_fail++; $display("FAIL capture_fields: got rs1=%0d rs2=%0d rd=%0d ctrl=%0h exp 5 6 10 200",
                               ex_rs1, ex_rs2, ex_rd, ex_ctrl);
        end
        // Invalid ID instruction: captured as invalid with zero ctrl.
        id_valid = 1'b0;
        tick();
        n_checks++;
        if ({ex_valid, ex_ctrl} !== 11'h0) begin
            n_fail++; $display("FAIL capture_invalid: got valid=%0h ctrl=%0h exp 0 0", ex_valid, ex_ctrl);
        end
    endtask

    task automatic test_bypass();
        clear_id();
        id_valid     = 1'b1;
        id_rs1       = 5'd5;
        id_rs2       = 5'd7;
        id_uses_rs1  = 1'b1;
        id_uses_rs2  = 1'b1;
        rf_rdata1    = 32'h0000_1234;
        rf_rdata2    = 32'h0;
        id_ctrl      = CtrlAdd;
        wb_reg_write = 1'b1;
        wb_rd        = 5'd7;
        wb_data      = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (ex_op2 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_op2: got %0h exp deadbeef", ex_op2);
        end
        n_checks++;
        if (ex_op1 !== 32'h0000_1234) begin
            n_fail++; $display("FAIL bypass_op1_nomatch: got %0h exp 1234", ex_op1);
        end
        // x0 never bypasses, even with a "write" to x0 pending.
        id_rs1  = 5'd0;
        id_rs2  = 5'd0;
        rf_rdata1 = 32'h0;
        wb_rd   = 5'd0;
        wb_data = 32'hAAAA_5555;
        tick();
        n_checks++;
        if ({ex_op1, ex_op2} !== 64'h0) begin
            n_fail++; $display("FAIL bypass_x0: got op1=%0h op2=%0h exp 0 0", ex_op1, ex_op2);
        end
        id_rs1    = 5'd9;
        rf_rdata1 = 32'h0000_0011;
        wb_rd     = 5'd9;
        wb_data   = 32'hCAFE_0001;
        tick();
        n_checks++;
        if (ex_op1 !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL bypass_op1: got %0h exp cafe0001", ex_op1);
        end
        wb_reg_write = 1'b0;
        tick();
        n_checks++;
        if (ex_op1 !== 32'h0000_0011) begin
            n_fail++; $display("FAIL bypass_no_wen: got %0h exp 11", ex_op1);
        end
    endtask

    task automatic test_load_use();
        drive_lw(5'd3, 32'h40);
        tick();
        drive_add_x3(32'h44);
        #1;
        n_checks++;
        if (stall_id !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall: got %0h exp 1", stall_id);
        end
        tick();
        n_checks++;
        if ({ex_valid, ex_ctrl} !== 11'h0) begin
            n_fail++; $display("FAIL lu_bubble: got valid=%0h ctrl=%0h exp 0 0", ex_valid, ex_ctrl);
        end
        n_checks++;
        if (bubble_count !== 32'd1) begin
            n_fail++; $display("FAIL lu_count: got %0d exp 1", bubble_count);
        end
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_release: got %0h exp 0", stall_id);
        end
        tick();
        n_checks++;
        if ({ex_valid, ex_pc, ex_rd, ex_ctrl} !== {1'b1, 32'h44, 5'd5, CtrlAdd}) begin
            n_fail++; $display("FAIL lu_capture_after: got valid=%0h pc=%0h rd=%0d ctrl=%0h exp 1 44 5 200",
                               ex_valid, ex_pc, ex_rd, ex_ctrl);
        end
    endtask

    task automatic test_flush();
        drive_lw(5'd3, 32'h60);
        tick();
        drive_add_x3(32'h300);
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %0h exp 0", stall_id);
        end
        tick();
        n_checks++;
        if ({ex_valid, ex_ctrl, ex_pc} !== 43'h0) begin
            n_fail++; $display("FAIL flush_clear: got valid=%0h ctrl=%0h pc=%0h exp 0 0 0",
                               ex_valid, ex_ctrl, ex_pc);
        end
        n_checks++;
        if (bubble_count !== 32'd1) begin
            n_fail++; $display("FAIL flush_count: got %0d exp 1", bubble_count);
        end
    endtask

    task automatic test_hold();
        drive_lw(5'd3, 32'h80);
        rf_rdata1 = 32'h77;
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_add_x3(32'h100 + 32'(i) * 4);
            rf_rdata1 = 32'(i);
            hold = 1'b1;
            #1;
            n_checks++;
            if (stall_id !== 1'b1) begin
                n_fail++; $display("FAIL hold_stall[%0d]: got %0h exp 1", i, stall_id);
            end
            tick();
            n_checks++;
            if ({ex_valid, ex_pc, ex_op1, ex_ctrl, bubble_count}
                    !== {1'b1, 32'h80, 32'h77, CtrlLw, 32'd1}) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: got valid=%0h pc=%0h op1=%0h ctrl=%0h cnt=%0d exp 1 80 77 360 1",
                                   i, ex_valid, ex_pc, ex_op1, ex_ctrl, bubble_count);
            end
        end
        hold = 1'b0;
        tick();
        n_checks++;
        if ({ex_valid, bubble_count} !== {1'b0, 32'd2}) begin
            n_fail++; $display("FAIL hold_release_bubble: got valid=%0h cnt=%0d exp 0 2", ex_valid, bubble_count);
        end
    endtask

    task automatic test_invalid_ex();
        // Invalid load with rd=3 leaves ex_rd=3 but ex_valid=0.
        drive_lw(5'd3, 32'h90);
        id_valid = 1'b0;
        tick();
        drive_add_x3(32'h94);
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL invalid_ex_stall: got %0h exp 0", stall_id);
        end
        // Load to x0 never creates a hazard.
        drive_lw(5'd0, 32'h98);
        tick();
        drive_add_x3(32'h9C);
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL x0_load_stall: got %0h exp 0", stall_id);
        end
        tick();
        n_checks++;
        if ({ex_valid, bubble_count} !== {1'b1, 32'd2}) begin
            n_fail++; $display("FAIL x0_load_capture: got valid=%0h cnt=%0d exp 1 2", ex_valid, bubble_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            drive_lw(5'd3, 32'h400);
            tick();
            drive_add_x3(32'h404);
            tick();
        end
        clear_id();
        id_valid = 1'b1;
        id_pc    = 32'h500;
        id_ctrl  = CtrlAdd;
        tick();
        n_checks++;
        if ({ex_valid, bubble_count} !== {1'b1, 32'd9}) begin
            n_fail++; $display("FAIL pre_reset_state: got valid=%0h cnt=%0d exp 1 9", ex_valid, bubble_count);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ex_valid, ex_pc, ex_ctrl, bubble_count} !== 75'h0) begin
            n_fail++; $display("FAIL async_reset: got valid=%0h pc=%0h ctrl=%0h cnt=%0d exp 0 0 0 0",
                               ex_valid, ex_pc, ex_ctrl, bubble_count);
        end
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_stall: got %0h exp 0", stall_id);
        end
        tick();
        reset = 1'b0;
        id_pc = 32'h600;
        tick();
        n_checks++;
        if ({ex_valid, ex_pc} !== {1'b1, 32'h600}) begin
            n_fail++; $display("FAIL first_capture: got valid=%0h pc=%0h exp 1 600", ex_valid, ex_pc);
        end
    endtask

    task automatic test_saturation();
        drive_lw(5'd3, 32'h700);
        tick();
        force dut.bubble_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_count_q;
        drive_add_x3(32'h704);
        #1;
        n_checks++;
        if (stall_id !== 1'b1) begin
            n_fail++; $display("FAIL sat_stall: got %0h exp 1", stall_id);
        end
        tick();
        n_checks++;
        if ({ex_valid, bubble_count} !== {1'b0, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL sat_count: got valid=%0h cnt=%0h exp 0 ffffffff", ex_valid, bubble_count);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_bypass();
        test_load_use();
        test_flush();
        test_hold();
        test_invalid_ex();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
